// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, polarity
// normalisation, counter debouncer, press/release strobes and long-press strobe.
module btn_debounce #(
   parameter int unsigned       NUM_CH          = 7,
   parameter int unsigned       DEBOUNCE_CYCLES = 250_000,
   parameter int unsigned       LONG_CYCLES     = 25_000_000,
   parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] btn_i,
   output logic [NUM_CH-1:0] state_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic [NUM_CH-1:0] long_o
);

   localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam bit          LONG_EN = (LONG_CYCLES > 0);
   localparam int unsigned LW      = LONG_EN ? $clog2(LONG_CYCLES + 1) : 1;

   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] L_LAST = LW'(LONG_EN ? LONG_CYCLES - 1 : 0);

   logic [NUM_CH-1:0] sync1_q, sync2_q;
   logic [NUM_CH-1:0] state_q, state_d;
   logic [NUM_CH-1:0] rise_q, rise_d;
   logic [NUM_CH-1:0] fall_q, fall_d;
   logic [NUM_CH-1:0] long_q, long_d;
   logic [DW-1:0]     dcnt_q [NUM_CH];
   logic [DW-1:0]     dcnt_d [NUM_CH];
   logic [LW-1:0]     lcnt_q [NUM_CH];
   logic [LW-1:0]     lcnt_d [NUM_CH];
   logic [NUM_CH-1:0] norm;

   // Normalised level: 1 = pressed, regardless of pad polarity.
   assign norm = sync2_q ^ INVERT_MASK;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the loop can leave a value unassigned and infer a latch.
      state_d = state_q;
      rise_d  = '0;
      fall_d  = '0;
      long_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dcnt_d[i] = '0;
         lcnt_d[i] = lcnt_q[i];

         if (norm[i] != state_q[i]) begin
            if (dcnt_q[i] == D_LAST) begin
               state_d[i] = norm[i];
               rise_d[i]  = norm[i];
               fall_d[i]  = ~norm[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end

         // Saturating long-press count; fires once on reaching L_MAX.
         if (!state_q[i]) begin
            lcnt_d[i] = '0;
         end else if (LONG_EN && (lcnt_q[i] < L_MAX)) begin
            lcnt_d[i] = lcnt_q[i] + 1'b1;
            long_d[i] = (lcnt_q[i] == L_LAST);
         end
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values; the counters are plain registers and are reset here too.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= INVERT_MASK;
         sync2_q <= INVERT_MASK;
         state_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         long_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            dcnt_q[i] <= '0;
            lcnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         long_q  <= long_d;
         for (int i = 0; i < NUM_CH; i++) begin
            dcnt_q[i] <= dcnt_d[i];
            lcnt_q[i] <= lcnt_d[i];
         end
      end
   end

   assign state_o = state_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign long_o  = long_q;

endmodule
